// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
// Load/store bus between the CPU MEM stage and the data-memory responder.
//   req_i    request valid (sampled by the responder only while idle)
//   we_i     1 = store, 0 = load
//   addr_i   byte address
//   wdata_i  store data
//   rdata_o  load data, meaningful on an ack of a load
//   ack_o    one-cycle completion pulse
//   err_o    completion with error, meaningful only with ack_o
//   stall_o  pipeline freeze request
// The _i/_o suffixes are from the responder's point of view.
// ---------------------------------------------------------------------------
interface dmem_responder_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic        err_o;
  logic        stall_o;

  // CPU side drives the request and observes the completion.
  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  rdata_o, ack_o, err_o, stall_o
  );

  // Responder side.
  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output rdata_o, ack_o, err_o, stall_o
  );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Multi-cycle data memory for the MEM stage. One word request is accepted at
// a time; the access is performed LATENCY cycles after acceptance and is
// completed with a one-cycle ack. stall_o holds the pipeline frozen from the
// cycle the request appears until the ack cycle.
//   clk_i    clock, rising edge
//   rst_n_i  asynchronous active-low reset (the array itself is not reset)
//   bus      dmem_responder_if.slave: req/we/addr/wdata in,
//            rdata/ack/err/stall out
// Parameters:
//   DEPTH    number of 32-bit words, word index = addr[31:2]
//   LATENCY  WAIT cycles before the access, 1..15
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  dmem_responder_if.slave  bus
);

  localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              ack;
  logic              stall;
  logic              access;
  logic              acc_err;
  logic [IDX_W-1:0]  idx;

  logic [31:0]       mem [DEPTH];

  // The range check uses the whole 30-bit word index so that high address
  // bits can never alias onto a valid word through the truncated index.
  assign idx     = addr_q[IDX_W+1:2];
  assign acc_err = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= DEPTH_W);
  assign access  = (state == WAIT) && (cnt == 4'd0);

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and outputs. stall follows req combinationally in IDLE so the
  // pipeline freezes in the very cycle the request shows up; it drops in DONE
  // so the pipeline advances together with the ack.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    ack       = 1'b0;
    unique case (state)
      IDLE: begin
        stall = bus.req_i;
        if (bus.req_i) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt == 4'd0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        ack       = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request latch, wait counter and completion registers. rdata_q only moves
  // on a load completion (forced to zero when the load errors).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && bus.req_i) begin
        we_q    <= bus.we_i;
        addr_q  <= bus.addr_i;
        wdata_q <= bus.wdata_i;
        cnt     <= CNT_LOAD;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        err_q <= acc_err;
        if (!we_q) begin
          rdata_q <= acc_err ? 32'd0 : mem[idx];
        end
      end
    end
  end

  // Backing array, deliberately not reset. A reset during WAIT forces the
  // state back to IDLE, so an in-flight store never reaches this write.
  always_ff @(posedge clk_i) begin
    if (access && we_q && !acc_err) begin
      mem[idx] <= wdata_q;
    end
  end

  assign bus.rdata_o = rdata_q;
  assign bus.ack_o   = ack;
  assign bus.err_o   = ack & err_q;
  assign bus.stall_o = stall;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Randomized and directed stimulus for dmem_responder. A transaction-level
// model predicts ack/err/stall/rdata each cycle from the acceptance cycle of
// the outstanding request; directed cases pin the model with literal values.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit check_en = 1'b0;

  // Reference model state: the outstanding request and the cycle its ack is due.
  logic [31:0] mem_model [DEPTH];
  bit          busy    = 1'b0;
  int          ack_cyc = 0;
  logic        p_we    = 1'b0;
  logic [31:0] p_addr  = 32'd0;
  logic [31:0] p_wdata = 32'd0;
  logic        p_err   = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  int          ack_cycles[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_i   = req;
    bus.we_i    = we;
    bus.addr_i  = addr;
    bus.wdata_i = wdata;
  endtask

  // Cycle counter; the model reads the pre-edge value at each rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Model update at each edge: the access happens on the edge entering the
  // ack cycle, which is LATENCY+1 cycles after the accepting cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    = 1'b0;
      m_rdata = 32'd0;
      p_err   = 1'b0;
    end else if (busy && cyc == ack_cyc) begin
      busy = 1'b0;
    end else if (busy) begin
      if (cyc == ack_cyc - 1) begin
        if (!p_err && p_we) mem_model[p_addr[31:2]] = p_wdata;
        if (!p_we) m_rdata = p_err ? 32'd0 : mem_model[p_addr[31:2]];
      end
    end else if (bus.req_i) begin
      busy    = 1'b1;
      p_we    = bus.we_i;
      p_addr  = bus.addr_i;
      p_wdata = bus.wdata_i;
      p_err   = (bus.addr_i[1:0] != 2'b00) || (bus.addr_i[31:2] >= DEPTH);
      ack_cyc = cyc + LATENCY + 1;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("ack",   32'(bus.ack_o),   32'(busy && cyc == ack_cyc));
      checkOutput("err",   32'(bus.err_o),   32'(busy && cyc == ack_cyc && p_err));
      checkOutput("stall", 32'(bus.stall_o), 32'(busy ? (cyc < ack_cyc) : bus.req_i));
      checkOutput("rdata", bus.rdata_o,      m_rdata);
      if (bus.ack_o) ack_cycles.push_back(cyc);
    end
  end

  // One complete transaction. pulse=1 drops req after one cycle, otherwise
  // req stays high until the idle cycle after the ack. scramble randomizes the
  // request fields once they have been sampled.
  task automatic doAccess(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit pulse, input bit scramble,
                          output int ack_at, output logic [31:0] rd, output logic er);
    int start;
    bit got;
    start  = cyc;
    got    = 1'b0;
    ack_at = -1;
    rd     = 32'd0;
    er     = 1'b0;
    applyStimulus(1'b1, we, addr, wdata);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.ack_o) begin
        got    = 1'b1;
        ack_at = cyc - start;
        rd     = bus.rdata_o;
        er     = bus.err_o;
      end
      @(posedge clk);
      #1;
      if (pulse || got) bus.req_i = 1'b0;
      if (scramble && !got) begin
        bus.we_i    = 1'($urandom);
        bus.addr_i  = $urandom;
        bus.wdata_i = $urandom;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("[TB] FAIL ack_timeout: got no ack expected ack within 20 cycles (cycle %0d)", cyc);
    end
  endtask

  function automatic logic [31:0] randAddr();
    case ($urandom_range(0, 9))
      0:       return 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
      1:       return 32'(DEPTH * 4) + 32'($urandom_range(0, 255)) * 4;
      2:       return 32'h4000_0000 | (32'($urandom_range(0, 15)) * 4);
      3, 4:    return 32'($urandom_range(252, 255)) * 4;
      default: return 32'($urandom_range(0, 15)) * 4;
    endcase
  endfunction

  initial begin
    int          at;
    int          start;
    logic [31:0] rd;
    logic        er;
    logic [31:0] old;

    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_en = 1'b1;

    // Reset state, including stall following req while in reset.
    checkOutput("rst_ack",   32'(bus.ack_o),   32'd0);
    checkOutput("rst_err",   32'(bus.err_o),   32'd0);
    checkOutput("rst_rdata", bus.rdata_o,      32'd0);
    checkOutput("rst_stall", 32'(bus.stall_o), 32'd0);
    bus.req_i = 1'b1;
    #1;
    checkOutput("rst_stall_req", 32'(bus.stall_o), 32'd1);
    bus.req_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Preload the words the rest of the run touches.
    for (int w = 0; w < 16; w++) doAccess(1'b1, 32'(w * 4), $urandom, 1'b0, 1'b0, at, rd, er);
    for (int w = 252; w < 256; w++) doAccess(1'b1, 32'(w * 4), $urandom, 1'b0, 1'b0, at, rd, er);

    // Store then load.
    doAccess(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, at, rd, er);
    checkOutput("store_lat", 32'(at), 32'd3);
    checkOutput("store_err", 32'(er), 32'd0);
    doAccess(1'b0, 32'h10, 32'd0, 1'b0, 1'b0, at, rd, er);
    checkOutput("load_lat",   32'(at), 32'd3);
    checkOutput("load_rdata", rd,      32'hDEADBEEF);
    doAccess(1'b1, 32'h14, 32'h0BADF00D, 1'b0, 1'b0, at, rd, er);
    checkOutput("rdata_hold", bus.rdata_o, 32'hDEADBEEF);

    // Error cases.
    doAccess(1'b1, 32'h12, 32'h11111111, 1'b0, 1'b0, at, rd, er);
    checkOutput("misalign_err", 32'(er), 32'd1);
    doAccess(1'b0, 32'h10, 32'd0, 1'b0, 1'b0, at, rd, er);
    checkOutput("misalign_nowrite", rd, 32'hDEADBEEF);
    doAccess(1'b0, 32'(DEPTH * 4), 32'd0, 1'b0, 1'b0, at, rd, er);
    checkOutput("range_err",   32'(er), 32'd1);
    checkOutput("range_rdata", rd,      32'd0);

    // req held high for three back-to-back loads.
    ack_cycles.delete();
    start = cyc;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(i < 12, 1'b0, 32'($urandom_range(0, 15)) * 4, 32'd0);
      @(posedge clk);
      #1;
    end
    checkOutput("b2b_count", 32'(ack_cycles.size()), 32'd3);
    for (int k = 0; k < 3 && k < ack_cycles.size(); k++)
      checkOutput("b2b_spacing", 32'(ack_cycles[k] - start), 32'(3 + 4 * k));

    // Single-cycle request pulse.
    doAccess(1'b0, 32'h14, 32'd0, 1'b1, 1'b0, at, rd, er);
    checkOutput("pulse_lat",   32'(at), 32'd3);
    checkOutput("pulse_rdata", rd,      32'h0BADF00D);

    // Reset during the second WAIT cycle of a store.
    old = mem_model[8];
    ack_cycles.delete();
    applyStimulus(1'b1, 1'b1, 32'h20, ~old);
    @(posedge clk);
    #1;
    bus.req_i = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ack",   32'(bus.ack_o),   32'd0);
    checkOutput("midrst_err",   32'(bus.err_o),   32'd0);
    checkOutput("midrst_rdata", bus.rdata_o,      32'd0);
    checkOutput("midrst_stall", 32'(bus.stall_o), 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midrst_noack", 32'(ack_cycles.size()), 32'd0);
    doAccess(1'b0, 32'h20, 32'd0, 1'b0, 1'b0, at, rd, er);
    checkOutput("midrst_keep", rd, old);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      doAccess(1'($urandom), randAddr(), $urandom, 1'($urandom), 1'($urandom), at, rd, er);
      checkOutput("rand_lat", 32'(at), 32'(LATENCY + 1));
      repeat ($urandom_range(0, 2)) begin
        applyStimulus(1'b0, 1'($urandom), $urandom, $urandom);
        @(posedge clk);
        #1;
      end
    end

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
